// File: rtl/input_buffer_port.sv
// input_buffer_port: router input FIFO with first-word fall-through head and a full margin for in-flight grants
// Define INBUF_ERR_EN to add sticky overflow/underflow flags.
module input_buffer_port #(
  parameter int FLIT_W = 32,
  parameter int DEPTH = 4,
  parameter int FULL_MARGIN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLIT_W-1:0]          data_i,
  input  logic                       valid_i,
  output logic                       full_o,
  input  logic                       pop_i,
  output logic [FLIT_W-1:0]          data_o,
  output logic [7:0]                 packet_addr_o,
  output logic                       packet_valid_o,
`ifdef INBUF_ERR_EN
  output logic                       err_overflow_o,
  output logic                       err_underflow_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_AT = CW'(DEPTH - FULL_MARGIN);
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  // A push into a full buffer is dropped even when a pop frees a slot: upstream was already told full.
  assign push = valid_i && (count != DEPTH_C);
  assign pop = pop_i && (count != '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_i;
  end
`ifdef INBUF_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow_o <= 1'b0;
      err_underflow_o <= 1'b0;
    end else begin
      err_overflow_o <= err_overflow_o || (valid_i && count == DEPTH_C);
      err_underflow_o <= err_underflow_o || (pop_i && count == '0);
    end
  end
`endif
  assign data_o = mem[rd_ptr];
  assign packet_addr_o = data_o[7:0];
  assign packet_valid_o = count != '0;
  assign full_o = count >= FULL_AT;
  assign count_o = count;
endmodule

// File: tb/tb_input_buffer_port.sv
// tb_input_buffer_port: scoreboard bench for input_buffer_port (DEPTH=4, FULL_MARGIN=1)
module tb_input_buffer_port;
  logic clk = 0, rst = 1, valid_i = 0, pop_i = 0;
  logic [31:0] data_i = 0, data_o;
  logic full_o, packet_valid_o;
  logic [7:0] packet_addr_o;
  logic [2:0] count_o;
`ifdef INBUF_ERR_EN
  logic err_overflow_o, err_underflow_o;
`endif
  logic [31:0] q[$];
  logic m_ov = 0, m_un = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  input_buffer_port #(.FLIT_W(32), .DEPTH(4), .FULL_MARGIN(1)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .full_o(full_o),
    .pop_i(pop_i), .data_o(data_o), .packet_addr_o(packet_addr_o),
    .packet_valid_o(packet_valid_o),
`ifdef INBUF_ERR_EN
    .err_overflow_o(err_overflow_o), .err_underflow_o(err_underflow_o),
`endif
    .count_o(count_o));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_state();
    chk("count", 32'(count_o), 32'(q.size()));
    chk("valid", 32'(packet_valid_o), 32'(q.size() != 0));
    chk("full", 32'(full_o), 32'(q.size() >= 3));
    if (q.size() != 0) begin
      chk("head_data", data_o, q[0]);
      chk("head_addr", 32'(packet_addr_o), 32'(q[0][7:0]));
    end
`ifdef INBUF_ERR_EN
    chk("err_ov", 32'(err_overflow_o), 32'(m_ov));
    chk("err_un", 32'(err_underflow_o), 32'(m_un));
`endif
  endtask
  task automatic step(input logic v, input logic [31:0] d, input logic p);
    logic push_ok, pop_ok;
    valid_i = v;
    data_i = d;
    pop_i = p;
    push_ok = v && q.size() < 4;
    pop_ok = p && q.size() > 0;
    #1;
    if (pop_ok) chk("pop_data", data_o, q[0]);
    if (v && q.size() == 4) m_ov = 1;
    if (p && q.size() == 0) m_un = 1;
    @(posedge clk);
    #1;
    if (pop_ok) void'(q.pop_front());
    if (push_ok) q.push_back(d);
    valid_i = 0;
    pop_i = 0;
    chk_state();
  endtask
  task automatic do_reset();
    rst = 1;
    #1;
    q.delete();
    m_ov = 0;
    m_un = 0;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_valid", 32'(packet_valid_o), 0);
    chk("rst_full", 32'(full_o), 0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    @(posedge clk);
    #1;
    do_reset();
    chk_state();
    step(1, 32'hA000_0011, 0);
    step(1, 32'hA000_0022, 0);
    step(1, 32'hA000_0033, 0);
    step(1, 32'hA000_00F4, 0);
    step(1, 32'hA000_0044, 1);
    repeat (3) step(0, 0, 1);
    step(0, 0, 1);
    step(1, 32'hC000_005A, 1);
    for (int i = 0; i < 10; i++) step(1, 32'hB000_0000 | 32'(i), 1);
    step(0, 0, 1);
    step(1, 32'hD000_0001, 0);
    step(1, 32'hD000_0002, 0);
    step(1, 32'hD000_0003, 0);
    do_reset();
    chk_state();
    repeat (3) step(0, 0, 1);
    step(1, 32'hE000_00E1, 0);
    step(0, 0, 1);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
